// File: rtl/cells_pkg.sv
// Cell-state encodings shared by the sand/water engine and the frame-commit pass,
// plus the state type of the commit FSM.
package cells_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_SAND  = 2'b01;
  localparam logic [1:0] CELL_WATER = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } commit_state_t;

endpackage

// File: rtl/frame_commit.sv
// Copies the next-frame RAM into display VRAM while clearing the RAM behind it,
// and merges at most one pending user draw into empty cells on the way.
module frame_commit
  import cells_pkg::*;
#(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
  output logic [ADDR_WIDTH-1:0] ram_rd_address_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_address_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] vram_wr_address_o,
  output logic [DATA_WIDTH-1:0] vram_wr_data_o,
  output logic                  vram_wr_en_o,
  input  logic                  draw_valid_i,
  input  logic [ADDR_WIDTH-1:0] draw_address_i,
  input  logic [DATA_WIDTH-1:0] draw_data_i,
  output logic                  draw_ready_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int                    CELLS     = ACTIVE_COLUMNS * ACTIVE_ROWS;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CELLS - 1);
  localparam logic [ADDR_WIDTH:0]   CELLS_EXT = (ADDR_WIDTH + 1)'(CELLS);

  commit_state_t r_state;
  commit_state_t w_next_state;

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_draw_addr;
  logic [DATA_WIDTH-1:0] r_draw_data;
  logic                  r_pending;

  logic w_last;
  logic w_draw_accept;
  logic w_draw_in_range;
  logic w_draw_hit;
  logic w_cell_empty;

  assign w_last          = (r_wr_ptr == LAST_ADDR);
  assign w_draw_accept   = draw_valid_i && !r_pending;
  assign w_draw_in_range = ({1'b0, draw_address_i} < CELLS_EXT);
  assign w_draw_hit      = (r_state == COPY) && r_pending && (r_wr_ptr == r_draw_addr);
  assign w_cell_empty    = (ram_rd_data_i == DATA_WIDTH'(CELL_EMPTY));
  assign draw_ready_o    = !r_pending;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The read pointer wraps to 0 one cycle before the final write, so the last
  // COPY cycle already reads address 0 and neither pointer ever holds N.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if ((r_state == IDLE) && start_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= ADDR_WIDTH'(1);
    end else if (r_state == COPY) begin
      r_wr_ptr <= w_last ? '0 : r_wr_ptr + ADDR_WIDTH'(1);
      r_rd_ptr <= (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + ADDR_WIDTH'(1);
    end
  end

  // A draw is consumed when its cell passes, whether it lands or is dropped.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_pending   <= 1'b0;
      r_draw_addr <= '0;
      r_draw_data <= '0;
    end else if (w_draw_accept) begin
      if (w_draw_in_range) begin
        r_pending   <= 1'b1;
        r_draw_addr <= draw_address_i;
        r_draw_data <= draw_data_i;
      end
    end else if (w_draw_hit) begin
      r_pending <= 1'b0;
    end
  end

  always_comb begin
    w_next_state      = r_state;
    ram_rd_address_o  = '0;
    ram_wr_address_o  = '0;
    ram_wr_data_o     = '0;
    ram_wr_en_o       = 1'b0;
    vram_wr_address_o = '0;
    vram_wr_data_o    = '0;
    vram_wr_en_o      = 1'b0;
    busy_o            = 1'b0;
    done_o            = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_next_state = COPY;
        end
      end
      COPY: begin
        busy_o            = 1'b1;
        ram_rd_address_o  = r_rd_ptr;
        ram_wr_en_o       = 1'b1;
        ram_wr_address_o  = r_wr_ptr;
        vram_wr_en_o      = 1'b1;
        vram_wr_address_o = r_wr_ptr;
        vram_wr_data_o    = (w_draw_hit && w_cell_empty) ? r_draw_data : ram_rd_data_i;
        if (w_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        busy_o       = 1'b1;
        done_o       = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_frame_commit.sv
// Self-checking bench for frame_commit on a 4x3 grid with a 1-cycle-latency RAM
// model; expected frames come from a cell-level reference of the commit pass.
module tb_frame_commit;
  import cells_pkg::*;

  localparam int COLS  = 4;
  localparam int ROWS  = 3;
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = 4;
  localparam int DW    = 2;

  typedef logic [2*CELLS-1:0] image_t;

  typedef struct {
    image_t          image;
    bit              drawEn;
    logic [AW-1:0]   drawAddr;
    logic [DW-1:0]   drawData;
    int              checkAddr;
    logic [DW-1:0]   expCell;
    bit              expReadyAccept;
    bit              expReadyPass;
  } vector_t;

  // Images are listed from address 11 down to address 0.
  localparam image_t IMG_A = {2'd1, 2'd2, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
  localparam image_t IMG_B = {2'd1, 2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          start_i = 1'b0;
  logic [DW-1:0] ram_rd_data_i = '0;
  logic [AW-1:0] ram_rd_address_o;
  logic [AW-1:0] ram_wr_address_o;
  logic [DW-1:0] ram_wr_data_o;
  logic          ram_wr_en_o;
  logic [AW-1:0] vram_wr_address_o;
  logic [DW-1:0] vram_wr_data_o;
  logic          vram_wr_en_o;
  logic          draw_valid_i = 1'b0;
  logic [AW-1:0] draw_address_i = '0;
  logic [DW-1:0] draw_data_i = '0;
  logic          draw_ready_o;
  logic          busy_o;
  logic          done_o;

  always #5 clk_i = ~clk_i;

  frame_commit #(
    .ACTIVE_COLUMNS(COLS),
    .ACTIVE_ROWS   (ROWS),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .start_i          (start_i),
    .ram_rd_data_i    (ram_rd_data_i),
    .ram_rd_address_o (ram_rd_address_o),
    .ram_wr_address_o (ram_wr_address_o),
    .ram_wr_data_o    (ram_wr_data_o),
    .ram_wr_en_o      (ram_wr_en_o),
    .vram_wr_address_o(vram_wr_address_o),
    .vram_wr_data_o   (vram_wr_data_o),
    .vram_wr_en_o     (vram_wr_en_o),
    .draw_valid_i     (draw_valid_i),
    .draw_address_i   (draw_address_i),
    .draw_data_i      (draw_data_i),
    .draw_ready_o     (draw_ready_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  int assertCount = 0;
  int failCount = 0;
  int cycleCount = 0;

  logic [DW-1:0] ramModel [16];
  logic [DW-1:0] vramSeen [16];
  int            vramWriteCycle [16];
  int            vramWriteCount = 0;
  int            ramClearCount = 0;
  int            doneCount = 0;
  int            lastDoneCycle = -1;
  int            busyCycles = 0;
  int            readyRiseCycle = -1;
  int            idleViolations = 0;
  int            rangeViolations = 0;
  int            doneCycles[$];
  logic          prevReady = 1'b1;
  logic [AW-1:0] sampRdAddr = '0;
  logic [AW-1:0] sampWrAddr = '0;
  logic [DW-1:0] sampWrData = '0;
  logic          sampWrEn = 1'b0;

  // Observe the DUT mid-cycle; the RAM model acts on what was seen at the edge.
  always @(negedge clk_i) begin
    sampRdAddr = ram_rd_address_o;
    sampWrAddr = ram_wr_address_o;
    sampWrData = ram_wr_data_o;
    sampWrEn   = ram_wr_en_o;
    if (ram_rd_address_o >= AW'(CELLS)) rangeViolations++;
    if (vram_wr_en_o) begin
      vramWriteCount++;
      if (vram_wr_address_o >= AW'(CELLS)) rangeViolations++;
      else begin
        vramSeen[vram_wr_address_o]       = vram_wr_data_o;
        vramWriteCycle[vram_wr_address_o] = cycleCount;
      end
    end
    if (ram_wr_en_o) begin
      ramClearCount++;
      if (ram_wr_address_o >= AW'(CELLS)) rangeViolations++;
    end
    if (busy_o) busyCycles++;
    if (done_o) begin
      doneCount++;
      lastDoneCycle = cycleCount;
      doneCycles.push_back(cycleCount);
    end
    if ((!busy_o || done_o) &&
        (ram_rd_address_o != '0 || ram_wr_address_o != '0 || ram_wr_data_o != '0 || ram_wr_en_o ||
         vram_wr_address_o != '0 || vram_wr_data_o != '0 || vram_wr_en_o))
      idleViolations++;
    if (draw_ready_o && !prevReady) readyRiseCycle = cycleCount;
    prevReady = draw_ready_o;
  end

  always @(posedge clk_i) begin
    cycleCount    <= cycleCount + 1;
    ram_rd_data_i <= ramModel[sampRdAddr];
    if (sampWrEn) ramModel[sampWrAddr] = sampWrData;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, failures so far %0d", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Reference: a pass copies every cell; a pending in-range draw lands only on an empty cell.
  function automatic image_t modelPass(input image_t img, input bit pend, input int addr,
                                       input logic [DW-1:0] data);
    image_t result = img;
    if (pend && addr < CELLS && img[2*addr +: 2] == CELL_EMPTY) result[2*addr +: 2] = data;
    return result;
  endfunction

  task automatic loadImage(input image_t img);
    for (int a = 0; a < CELLS; a++) ramModel[a] = img[2*a +: 2];
  endtask

  task automatic clearCapture();
    for (int a = 0; a < 16; a++) begin
      vramSeen[a]       = '0;
      vramWriteCycle[a] = -1;
    end
    vramWriteCount = 0;
    ramClearCount  = 0;
    doneCount      = 0;
    lastDoneCycle  = -1;
    busyCycles     = 0;
    readyRiseCycle = -1;
    doneCycles.delete();
  endtask

  task automatic applyDraw(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input bit expReady);
    draw_valid_i   = 1'b1;
    draw_address_i = addr;
    draw_data_i    = data;
    waitCycles(1);
    draw_valid_i = 1'b0;
    checkOutput({name, " readyAfterAccept"}, int'(draw_ready_o), int'(expReady));
  endtask

  task automatic startPass(output int t);
    clearCapture();
    start_i = 1'b1;
    t = cycleCount;
    waitCycles(1);
    start_i = 1'b0;
  endtask

  task automatic waitPassEnd();
    int guard = 0;
    while (doneCount == 0 && guard < 40) begin
      waitCycles(1);
      guard++;
    end
    waitCycles(1);
  endtask

  task automatic checkPass(input string name, input int t, input image_t expImage);
    int lateWrites = 0;
    int dirty = 0;
    checkOutput({name, " doneCount"}, doneCount, 1);
    checkOutput({name, " doneCycle"}, lastDoneCycle, t + CELLS + 1);
    checkOutput({name, " vramWrites"}, vramWriteCount, CELLS);
    checkOutput({name, " ramWrites"}, ramClearCount, CELLS);
    checkOutput({name, " busyCycles"}, busyCycles, CELLS + 1);
    checkOutput({name, " idleAfterPass"}, int'(busy_o), 0);
    for (int a = 0; a < CELLS; a++) begin
      checkOutput($sformatf("%s vram[%0d]", name, a), int'(vramSeen[a]), int'(expImage[2*a +: 2]));
      if (vramWriteCycle[a] != t + 1 + a) lateWrites++;
      if (ramModel[a] != CELL_EMPTY) dirty++;
    end
    checkOutput({name, " writeTiming"}, lateWrites, 0);
    checkOutput({name, " ramCleared"}, dirty, 0);
  endtask

  task automatic applyStimulus(input string name, input vector_t v);
    int t;
    image_t expImage;
    loadImage(v.image);
    if (v.drawEn) applyDraw(name, v.drawAddr, v.drawData, v.expReadyAccept);
    startPass(t);
    waitPassEnd();
    expImage = modelPass(v.image, v.drawEn, int'(v.drawAddr), v.drawData);
    checkPass(name, t, expImage);
    checkOutput({name, " cell"}, int'(vramSeen[v.checkAddr]), int'(v.expCell));
    checkOutput({name, " readyAfterPass"}, int'(draw_ready_o), int'(v.expReadyPass));
    if (v.drawEn && !v.expReadyAccept)
      checkOutput({name, " readyRiseCycle"}, readyRiseCycle, t + int'(v.drawAddr) + 2);
  endtask

  initial begin
    vector_t vectors[8];
    vector_t rv;
    image_t  img;
    int      t;
    int      t2;

    for (int a = 0; a < 16; a++) ramModel[a] = '0;
    clearCapture();

    vectors[0] = '{IMG_A, 1'b0, 4'd0,  CELL_EMPTY, 11, CELL_SAND,  1'b1, 1'b1};
    vectors[1] = '{IMG_B, 1'b1, 4'd5,  CELL_SAND,   5, CELL_SAND,  1'b0, 1'b1};
    vectors[2] = '{IMG_A, 1'b1, 4'd5,  CELL_SAND,   5, CELL_WATER, 1'b0, 1'b1};
    vectors[3] = '{IMG_A, 1'b1, 4'd0,  CELL_WATER,  0, CELL_WATER, 1'b0, 1'b1};
    vectors[4] = '{IMG_B, 1'b1, 4'd11, CELL_WATER, 11, CELL_SAND,  1'b0, 1'b1};
    vectors[5] = '{IMG_A, 1'b1, 4'd12, CELL_SAND,   0, CELL_EMPTY, 1'b1, 1'b1};
    vectors[6] = '{IMG_B, 1'b1, 4'd10, 2'b11,      10, 2'b11,      1'b0, 1'b1};
    vectors[7] = '{IMG_B, 1'b1, 4'd1,  CELL_WATER,  1, CELL_WATER, 1'b0, 1'b1};

    #2;
    checkOutput("reset ready", int'(draw_ready_o), 1);
    checkOutput("reset busy", int'(busy_o), 0);
    checkOutput("reset done", int'(done_o), 0);
    checkOutput("reset vramWrEn", int'(vram_wr_en_o), 0);
    checkOutput("reset ramWrEn", int'(ram_wr_en_o), 0);
    checkOutput("reset rdAddr", int'(ram_rd_address_o), 0);
    waitCycles(2);
    reset_i = 1'b1;
    waitCycles(2);

    for (int i = 0; i < 8; i++) applyStimulus($sformatf("vec%0d", i), vectors[i]);

    for (int i = 0; i < 20; i++) begin
      for (int a = 0; a < CELLS; a++) img[2*a +: 2] = DW'($urandom_range(0, 3));
      rv.image          = img;
      rv.drawEn         = 1'($urandom_range(0, 1));
      rv.drawAddr       = AW'($urandom_range(0, 13));
      rv.drawData       = DW'($urandom_range(1, 3));
      rv.checkAddr      = (int'(rv.drawAddr) < CELLS) ? int'(rv.drawAddr) : 0;
      rv.expCell        = modelPass(img, rv.drawEn, int'(rv.drawAddr), rv.drawData)[2*rv.checkAddr +: 2];
      rv.expReadyAccept = (int'(rv.drawAddr) >= CELLS);
      rv.expReadyPass   = 1'b1;
      applyStimulus($sformatf("rand%0d", i), rv);
    end

    // A draw accepted after its cell has gone by waits for the following pass.
    img = IMG_A;
    img[5:4] = CELL_EMPTY;
    loadImage(img);
    startPass(t);
    waitCycles(4);
    applyDraw("latedraw", 4'd2, CELL_SAND, 1'b0);
    waitPassEnd();
    checkPass("latedraw pass1", t, img);
    checkOutput("latedraw stillPending", int'(draw_ready_o), 0);
    loadImage(img);
    startPass(t2);
    waitPassEnd();
    checkPass("latedraw pass2", t2, modelPass(img, 1'b1, 2, CELL_SAND));
    checkOutput("latedraw released", int'(draw_ready_o), 1);

    // Reset in the middle of a pass, with a draw pending.
    loadImage(IMG_A);
    applyDraw("midreset", 4'd3, CELL_SAND, 1'b0);
    startPass(t);
    waitCycles(t + 6 - cycleCount);
    reset_i = 1'b0;
    #1;
    checkOutput("midreset busy", int'(busy_o), 0);
    checkOutput("midreset vramWrEn", int'(vram_wr_en_o), 0);
    checkOutput("midreset ramWrEn", int'(ram_wr_en_o), 0);
    checkOutput("midreset ready", int'(draw_ready_o), 1);
    waitCycles(1);
    reset_i = 1'b1;
    waitCycles(20);
    checkOutput("midreset noDone", doneCount, 0);
    loadImage(IMG_A);
    startPass(t);
    waitPassEnd();
    checkPass("afterreset", t, IMG_A);

    // start_i held high gives back-to-back passes, one done_o each.
    loadImage(IMG_A);
    clearCapture();
    start_i = 1'b1;
    t = cycleCount;
    waitCycles(41);
    start_i = 1'b0;
    waitCycles(6);
    checkOutput("held doneCount", doneCycles.size(), 3);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("held doneCycle%0d", k),
                  (k < doneCycles.size()) ? doneCycles[k] : -1, t + CELLS + 1 + k * (CELLS + 2));
    checkOutput("held vramWrites", vramWriteCount, 3 * CELLS);
    checkOutput("held busyCycles", busyCycles, 3 * (CELLS + 1));
    checkOutput("held idleAtEnd", int'(busy_o), 0);

    checkOutput("idle outputs zero", idleViolations, 0);
    checkOutput("addresses in range", rangeViolations, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
